// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: bus widths, data-memory
// window and the 2-bit sequencer state encodings.
package data_mem_arbiter_pkg;

    localparam int ADDRESS_LEN     = 32;
    localparam int INSTRUCTION_LEN = 32;
    localparam int DMEM_BASE       = 1024;
    localparam int DMEM_BYTES      = 256;

    // Sequencer states (kept as plain 2-bit constants for legacy tools)
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_DONE   = 2'b10;

    // A word access needs the two low address bits clear
    function automatic logic word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin picker. When both requesters are valid the one
// that did not win last time is chosen; a lone requester always wins.
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_any,
    output logic grant_idx
);

    // Combinational grant selection
    always_comb begin
        grant_any = valid0 | valid1;
        grant_idx = 1'b0;
        if (valid0 && valid1) begin
            grant_idx = ~last_grant;
        end else if (valid1) begin
            grant_idx = 1'b1;
        end else begin
            grant_idx = 1'b0;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported data memory.
// Port 0 is the CPU MEM stage, port 1 the loader/debug master. Each granted
// access holds the memory strobes for WAIT_CYCLES cycles, then reports on the
// granted port with a one-cycle done pulse. Misaligned or out-of-window
// addresses are rejected without any memory strobe.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDRESS_LEN,
    parameter int DATA_W      = INSTRUCTION_LEN,
    parameter int BASE_ADDR   = DMEM_BASE,
    parameter int MEM_BYTES   = DMEM_BYTES,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,
    output logic              req0_err,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,
    output logic              req1_err,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Window bounds carry one extra bit so BASE+SIZE cannot wrap
    localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] WIN_HI = (ADDR_W+1)'(BASE_ADDR) + (ADDR_W+1)'(MEM_BYTES);

    logic              grant_any_s;
    logic              grant_idx_s;
    logic              cand_we_s;
    logic [ADDR_W-1:0] cand_addr_s;
    logic [DATA_W-1:0] cand_wdata_s;
    logic              cand_bad_s;
    logic              access_s;
    logic              last_beat_s;
    logic              reject_s;
    logic              enter_done_s;
    logic              done_port_s;

    logic [1:0]        state_r;
    logic              last_grant_r;
    logic              grant_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              done0_r;
    logic              err0_r;
    logic [DATA_W-1:0] rdata0_r;
    logic              done1_r;
    logic              err1_r;
    logic [DATA_W-1:0] rdata1_r;

    rr_arbiter2 u_rr (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_r),
        .grant_any  (grant_any_s),
        .grant_idx  (grant_idx_s)
    );

    // Select the fields of the port the arbiter would grant and screen its address
    always_comb begin
        cand_we_s    = 1'b0;
        cand_addr_s  = {ADDR_W{1'b0}};
        cand_wdata_s = {DATA_W{1'b0}};
        if (grant_idx_s) begin
            cand_we_s    = req1_we;
            cand_addr_s  = req1_addr;
            cand_wdata_s = req1_wdata;
        end else begin
            cand_we_s    = req0_we;
            cand_addr_s  = req0_addr;
            cand_wdata_s = req0_wdata;
        end
        cand_bad_s = !word_aligned(cand_addr_s[1:0])
                   || ({1'b0, cand_addr_s} <  WIN_LO)
                   || ({1'b0, cand_addr_s} >= WIN_HI);
    end

    // Sequencer events: last access beat, rejection, and which port reports next
    always_comb begin
        access_s     = (state_r == ST_ACCESS);
        last_beat_s  = access_s && (cnt_r == CNT_ZERO);
        reject_s     = (state_r == ST_IDLE) && grant_any_s && cand_bad_s;
        enter_done_s = reject_s || last_beat_s;
        if (state_r == ST_IDLE) begin
            done_port_s = grant_idx_s;
        end else begin
            done_port_s = grant_r;
        end
    end

    // Memory strobes are decoded from state so a reset drops them at once
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = {ADDR_W{1'b0}};
        mem_write_data = {DATA_W{1'b0}};
        if (access_s) begin
            mem_read       = !we_r;
            mem_write      = we_r && (cnt_r == CNT_ZERO);
            mem_address    = addr_r;
            mem_write_data = wdata_r;
        end else begin
            mem_read       = 1'b0;
            mem_write      = 1'b0;
            mem_address    = {ADDR_W{1'b0}};
            mem_write_data = {DATA_W{1'b0}};
        end
    end

    // Sequencer state, grant bookkeeping and latched request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            grant_r      <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            cnt_r        <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_any_s) begin
                        grant_r      <= grant_idx_s;
                        last_grant_r <= grant_idx_s;
                        we_r         <= cand_we_s;
                        addr_r       <= cand_addr_s;
                        wdata_r      <= cand_wdata_s;
                        if (cand_bad_s) begin
                            state_r <= ST_DONE;
                            cnt_r   <= CNT_ZERO;
                        end else begin
                            state_r <= ST_ACCESS;
                            cnt_r   <= CNT_LOAD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-port completion pulse, error flag and held read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done0_r  <= 1'b0;
            err0_r   <= 1'b0;
            rdata0_r <= {DATA_W{1'b0}};
            done1_r  <= 1'b0;
            err1_r   <= 1'b0;
            rdata1_r <= {DATA_W{1'b0}};
        end else begin
            done0_r <= enter_done_s && (done_port_s == 1'b0);
            err0_r  <= reject_s     && (done_port_s == 1'b0);
            done1_r <= enter_done_s && (done_port_s == 1'b1);
            err1_r  <= reject_s     && (done_port_s == 1'b1);
            if (last_beat_s && !we_r) begin
                if (grant_r) begin
                    rdata1_r <= mem_read_data;
                end else begin
                    rdata0_r <= mem_read_data;
                end
            end else begin
                rdata0_r <= rdata0_r;
                rdata1_r <= rdata1_r;
            end
        end
    end

    assign req0_done  = done0_r;
    assign req0_err   = err0_r;
    assign req0_rdata = rdata0_r;
    assign req1_done  = done1_r;
    assign req1_err   = err1_r;
    assign req1_rdata = rdata1_r;

endmodule
